// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID latch.
// Holds the PC and drives the instruction-memory request with an ihit handshake.
// It also buffers a fetched word while ID is stalled and applies jump/branch
// redirects that are resolved in MEM.
// Optional feature macro: FETCH_PERF_EN adds saturating stall/flush event counters.
// When the macro is undefined, both counter outputs are tied to zero.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        pc_stall,
  input  logic        enable_ID,
  input  logic        flush_ID,
  input  logic        dmem_busy,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pcplus4_ID,
  output logic        valid_ID,
  output logic [1:0]  fetch_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    HALT  = 2'b10
  } state_t;

  // PC increment; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == HALT_OP;
  endfunction

  // IF stage (p0) state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_p0;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf_p0;

  // IF/ID latch (p1) state
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_pc4_p1;
  logic        r_vld_p1;

  // Per-cycle control decoded from state and hazard inputs
  logic        w_accept;
  logic        w_buf_ld;
  logic        w_id_ld;
  logic        w_id_nop;
  logic        w_word_vld;
  logic        w_imemren;
  logic [31:0] w_id_word;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;

  // ID can only take a word when every hazard control agrees.
  assign w_accept   = enable_ID & ~pc_stall & ~dmem_busy & ~flush_ID;
  // Redirect targets are always word aligned.
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_inc   = pc_inc(r_pc_p0);

  // Next-state, next-PC and latch-control decode (defaults first).
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc_p0;
    w_buf_ld    = 1'b0;
    w_id_ld     = 1'b0;
    w_id_nop    = 1'b0;
    w_id_word   = imemload;
    w_word_vld  = 1'b0;
    w_imemren   = 1'b0;
    case (r_state)
      FETCH: begin
        w_imemren  = 1'b1;
        w_word_vld = ihit;
        if (redirect) begin
          // Returned word (if any) is on the wrong path; a load that
          // would have happened becomes a NOP in ID instead.
          w_pc_nxt = w_redir_pc;
          w_id_nop = ihit & w_accept;
        end else if (ihit) begin
          if (w_accept) begin
            w_id_ld  = 1'b1;
            w_pc_nxt = w_pc_inc;
            if (is_halt(imemload[31:26])) begin
              w_state_nxt = HALT;
            end
          end else begin
            w_buf_ld    = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        w_word_vld = 1'b1;
        w_id_word  = r_buf_p0;
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_id_nop    = w_accept;
          w_state_nxt = FETCH;
        end else if (w_accept) begin
          w_id_ld     = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = is_halt(r_buf_p0[31:26]) ? HALT : FETCH;
        end
      end
      HALT: begin
        // Only a redirect (a HALT squashed behind a jump) restarts fetch.
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc_p0 <= PC_RESET;
    end else begin
      r_pc_p0 <= w_pc_nxt;
    end
  end

  // Hold buffer: captures the returned word when ID cannot take it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_buf_p0 <= '0;
    end else if (w_buf_ld) begin
      r_buf_p0 <= imemload;
    end
  end

  // ---- IF -> ID boundary ----
  // IF/ID latch: flush beats load beats hold; a redirected load becomes a NOP.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr_p1 <= '0;
      r_pc_p1    <= '0;
      r_pc4_p1   <= '0;
      r_vld_p1   <= 1'b0;
    end else if (flush_ID || w_id_nop) begin
      r_instr_p1 <= '0;
      r_pc_p1    <= '0;
      r_pc4_p1   <= '0;
      r_vld_p1   <= 1'b0;
    end else if (w_id_ld) begin
      r_instr_p1 <= w_id_word;
      r_pc_p1    <= r_pc_p0;
      r_pc4_p1   <= w_pc_inc;
      r_vld_p1   <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Stall counter: a valid word was available but ID refused it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (w_word_vld && !w_accept) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // Flush counter: one count per cycle with flush_ID or redirect.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_flush_cnt <= '0;
    end else if (flush_ID || redirect) begin
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // w_word_vld only feeds the counters; fold it in harmlessly.
  logic w_unused_perf;
  assign w_unused_perf = w_word_vld;
  assign stall_cnt     = (32'(w_unused_perf) & 32'd0);
  assign flush_cnt     = 32'd0;
`endif

  assign imemREN     = w_imemren;
  assign imemaddr    = r_pc_p0;
  assign instr_ID    = r_instr_p1;
  assign pc_ID       = r_pc_p1;
  assign pcplus4_ID  = r_pc4_p1;
  assign valid_ID    = r_vld_p1;
  assign fetch_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized bench for fetch_stage with a
// transaction-level reference model (PC value, pending-word queue, halted flag).
module tb_fetch_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP  = 6'b111111;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        pc_stall = 1'b0;
  logic        enable_ID = 1'b1;
  logic        flush_ID = 1'b0;
  logic        dmem_busy = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic [31:0] pcplus4_ID;
  logic        valid_ID;
  logic [1:0]  fetch_state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_RESET(PC_RESET), .HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .pc_stall(pc_stall),
    .enable_ID(enable_ID), .flush_ID(flush_ID), .dmem_busy(dmem_busy),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_ID(instr_ID),
    .pc_ID(pc_ID), .pcplus4_ID(pcplus4_ID), .valid_ID(valid_ID),
    .fetch_state(fetch_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  bit          m_halt;
  logic [31:0] m_instr, m_pcid, m_pc4;
  bit          m_valid;
  logic [31:0] m_stall, m_flush;

  always @(posedge CLK or negedge nRST) begin : model
    bit          acc, got, do_load, do_nop;
    logic [31:0] word, rpc, ld_pc;
    if (!nRST) begin
      m_pc = PC_RESET; m_held.delete(); m_halt = 0;
      m_instr = 0; m_pcid = 0; m_pc4 = 0; m_valid = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      acc = enable_ID && !pc_stall && !dmem_busy && !flush_ID;
      rpc = redirect_pc & ~32'h3;
      got = 0; word = 0; do_load = 0; do_nop = 0; ld_pc = m_pc;
      if (m_halt) begin
        if (redirect) begin m_pc = rpc; m_halt = 0; end
      end else begin
        if (m_held.size() != 0) begin got = 1; word = m_held[0]; end
        else if (ihit) begin got = 1; word = imemload; end
        if (got && !acc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (redirect) begin
          m_held.delete(); m_pc = rpc; do_nop = got && acc;
        end else if (got && acc) begin
          do_load = 1; m_held.delete(); m_pc = m_pc + 4;
          if (word[31:26] == HALT_OP) m_halt = 1;
        end else if (got && m_held.size() == 0) begin
          m_held.push_back(word);
        end
      end
      if ((flush_ID || redirect) && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (flush_ID || do_nop) begin
        m_instr = 0; m_pcid = 0; m_pc4 = 0; m_valid = 0;
      end else if (do_load) begin
        m_instr = word; m_pcid = ld_pc; m_pc4 = ld_pc + 4; m_valid = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    logic [1:0] e_state;
    if (chk_on) begin
      e_state = m_halt ? 2'b10 : ((m_held.size() != 0) ? 2'b01 : 2'b00);
      chk("state",   32'(fetch_state), 32'(e_state));
      chk("imemREN", 32'(imemREN), 32'(!m_halt && m_held.size() == 0));
      chk("imemaddr", imemaddr, m_pc);
      chk("instr_ID", instr_ID, m_instr);
      chk("pc_ID", pc_ID, m_pcid);
      chk("pcplus4_ID", pcplus4_ID, m_pc4);
      chk("valid_ID", 32'(valid_ID), 32'(m_valid));
`ifdef FETCH_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`else
      chk("stall_cnt", stall_cnt, 32'd0);
      chk("flush_cnt", flush_cnt, 32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit ih, input logic [31:0] ld, input bit ps, input bit en,
                       input bit fl, input bit db, input bit rd, input logic [31:0] rp);
    ihit = ih; imemload = ld; pc_stall = ps; enable_ID = en;
    flush_ID = fl; dmem_busy = db; redirect = rd; redirect_pc = rp;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic async_reset();
    idle();
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("arst_state", 32'(fetch_state), 32'd0);
    chk("arst_valid", 32'(valid_ID), 32'd0);
    chk("arst_instr", instr_ID, 32'd0);
    chk("arst_addr", imemaddr, PC_RESET);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  localparam logic [31:0] WA = 32'h2001_0001;
  localparam logic [31:0] WB = 32'h8C22_0004;
  localparam logic [31:0] WC = 32'hAC23_0008;
  localparam logic [31:0] WH = 32'hFC00_0000;
  localparam logic [31:0] WE = 32'h2002_0002;
  localparam logic [31:0] WF = 32'h2003_0003;

  initial begin
    logic [31:0] w;
    idle();
    #2 nRST = 1'b0;
    step(); step();
    nRST = 1'b1;
    chk_on = 1'b1;
    // reset state
    chk("rst_instr", instr_ID, 32'h0);
    chk("rst_valid", 32'(valid_ID), 32'd0);
    chk("rst_state", 32'(fetch_state), 32'd0);
    chk("rst_ren", 32'(imemREN), 32'd1);
    chk("rst_addr", imemaddr, PC_RESET);

    // A,B,C back to back
    drive(1, WA, 0, 1, 0, 0, 0, 0); step();
    chk("seq_A", instr_ID, WA); chk("seq_pcA", pc_ID, 32'h0); chk("seq_p4A", pcplus4_ID, 32'h4);
    drive(1, WB, 0, 1, 0, 0, 0, 0); step();
    chk("seq_B", instr_ID, WB); chk("seq_pcB", pc_ID, 32'h4); chk("seq_p4B", pcplus4_ID, 32'h8);
    drive(1, WC, 0, 1, 0, 0, 0, 0); step();
    chk("seq_C", instr_ID, WC); chk("seq_pcC", pc_ID, 32'h8); chk("seq_p4C", pcplus4_ID, 32'hC);
    chk("seq_addr", imemaddr, 32'hC);

    // stall into HOLD then release
    async_reset();
    drive(1, WA, 0, 1, 0, 0, 0, 0); step();
    drive(1, WB, 1, 1, 0, 0, 0, 0); step();
    chk("hold_state", 32'(fetch_state), 32'd1);
    chk("hold_ren", 32'(imemREN), 32'd0);
    chk("hold_instr", instr_ID, WA);
    drive(0, 32'h0, 1, 1, 0, 0, 0, 0); step(); step();
    chk("hold_state3", 32'(fetch_state), 32'd1);
    chk("hold_instr3", instr_ID, WA);
    idle(); step();
    chk("rel_instr", instr_ID, WB);
    chk("rel_pc", imemaddr, 32'h8);
    chk("rel_pcid", pc_ID, 32'h4);
    chk("rel_state", 32'(fetch_state), 32'd0);

    // redirect with ihit: word discarded, target aligned
    drive(1, 32'h0000_0020, 0, 1, 0, 0, 1, 32'h0000_0103); step();
    chk("redir_pc", imemaddr, 32'h100);
    chk("redir_instr", instr_ID, 32'h0);
    chk("redir_valid", 32'(valid_ID), 32'd0);

    // HALT then restart by redirect
    drive(1, WH, 0, 1, 0, 0, 0, 0); step();
    chk("halt_state", 32'(fetch_state), 32'd2);
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_instr", instr_ID, WH);
    drive(1, WA, 0, 1, 0, 0, 0, 0); step();
    chk("halt_frozen", imemaddr, 32'h104);
    chk("halt_state2", 32'(fetch_state), 32'd2);
    drive(0, 32'h0, 0, 1, 0, 0, 1, 32'h40); step();
    chk("unhalt_state", 32'(fetch_state), 32'd0);
    chk("unhalt_addr", imemaddr, 32'h40);
    chk("unhalt_ren", 32'(imemREN), 32'd1);

    // PC wrap
    drive(0, 32'h0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC); step();
    chk("wrap_pre", imemaddr, 32'hFFFF_FFFC);
    drive(1, WE, 0, 1, 0, 0, 0, 0); step();
    chk("wrap_pc", imemaddr, 32'h0);
    chk("wrap_pcid", pc_ID, 32'hFFFF_FFFC);
    chk("wrap_p4", pcplus4_ID, 32'h0);

    // flush with enable: latch cleared, word parked
    drive(1, WF, 0, 1, 1, 0, 0, 0); step();
    chk("flush_instr", instr_ID, 32'h0);
    chk("flush_valid", 32'(valid_ID), 32'd0);
    chk("flush_pcid", pc_ID, 32'h0);
    chk("flush_state", 32'(fetch_state), 32'd1);
    idle(); step();
    chk("flush_rel", instr_ID, WF);
    chk("flush_addr", imemaddr, 32'h4);

    // counters: 5 blocked cycles then 2 redirects
    async_reset();
    drive(1, WA, 1, 1, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 1, 0, 0, 0, 0); step();
    end
    drive(0, 32'h0, 0, 1, 0, 0, 1, 32'h200); step();
    drive(0, 32'h0, 0, 1, 0, 0, 1, 32'h300); step();
`ifdef FETCH_PERF_EN
    chk("perf_stall", stall_cnt, 32'd5);
    chk("perf_flush", flush_cnt, 32'd2);
`else
    chk("perf_stall", stall_cnt, 32'd0);
    chk("perf_flush", flush_cnt, 32'd0);
`endif

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) begin
        async_reset();
      end else begin
        w = $urandom;
        if ($urandom_range(0, 7) == 0) w[31:26] = HALT_OP;
        drive($urandom_range(0, 9) < 7, w,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0,
              $urandom);
        step();
      end
    end

    idle(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
